// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_pkg : shared constants for the MEM-stage access unit
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACC_BOT = 2'd1;
  localparam logic [1:0] ACC_TOP = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_stage_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_access_unit : byte-serial load/store of a top/bot pair over an
//                         8-bit ready-handshaked data-memory port
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mem_stage_access_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] ex_mem_top,
  input  logic [DATA_WIDTH-1:0] ex_mem_bot,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rd_top,
  output logic [DATA_WIDTH-1:0] rd_bot,
  output logic                  rd_valid
);

  logic [1:0]            state_q,  state_d;
  logic                  write_q,  write_d;
  logic                  wide_q,   wide_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] top_q,    top_d;
  logic [DATA_WIDTH-1:0] bot_q,    bot_d;
  logic [DATA_WIDTH-1:0] rd_top_q, rd_top_d;
  logic [DATA_WIDTH-1:0] rd_bot_q, rd_bot_d;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Natural-width add wraps the top byte address past the end of memory.
  assign addr_inc = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    wide_d    = wide_q;
    addr_d    = addr_q;
    top_d     = top_q;
    bot_d     = bot_q;
    rd_top_d  = rd_top_q;
    rd_bot_d  = rd_bot_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    stall     = 1'b0;
    rd_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          write_d = req_write;
          wide_d  = req_wide;
          addr_d  = req_addr;
          top_d   = ex_mem_top;
          bot_d   = ex_mem_bot;
          state_d = ACC_BOT;
        end
      end
      ACC_BOT: begin
        stall     = 1'b1;
        mem_addr  = addr_q;
        mem_we    = write_q;
        mem_re    = !write_q;
        mem_wdata = write_q ? bot_q : '0;
        if (mem_ready) begin
          if (!write_q) begin
            rd_bot_d = mem_rdata;
            if (!wide_q) rd_top_d = '0;
          end
          state_d = wide_q ? ACC_TOP : DONE;
        end
      end
      ACC_TOP: begin
        stall     = 1'b1;
        mem_addr  = addr_inc;
        mem_we    = write_q;
        mem_re    = !write_q;
        mem_wdata = write_q ? top_q : '0;
        if (mem_ready) begin
          if (!write_q) rd_top_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        // EX/MEM still holds the finished instruction here, so req_valid is ignored.
        rd_valid = !write_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      wide_q   <= 1'b0;
      addr_q   <= '0;
      top_q    <= '0;
      bot_q    <= '0;
      rd_top_q <= '0;
      rd_bot_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      wide_q   <= wide_d;
      addr_q   <= addr_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      rd_top_q <= rd_top_d;
      rd_bot_q <= rd_bot_d;
    end
  end

  assign rd_top = rd_top_q;
  assign rd_bot = rd_bot_q;

endmodule
`default_nettype wire

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
MEM-stage consumer of the EX/MEM data pair (top/bot bytes) that the execute stage places in the EX/MEM register.
- Loads and stores one byte (narrow) or two bytes (wide) over a single 8-bit data-memory port with a ready handshake.
- Stalls the pipeline for the duration of each access.
- On loads, presents the result as a top/bot byte pair for the MEM/WB register.

Parameters:
ADDR_WIDTH, 16, data-memory byte-address width
DATA_WIDTH, 8, memory port width; also the width of each of the top/bot bytes

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  EX/MEM holds a memory instruction
req_write  input  1  1 = store, 0 = load
req_wide  input  1  1 = two-byte access, 0 = one byte (bot only)
req_addr  input  ADDR_WIDTH  byte address of the bot byte
ex_mem_top  input  DATA_WIDTH  store data, high byte
ex_mem_bot  input  DATA_WIDTH  store data, low byte
mem_addr  output  ADDR_WIDTH  memory port address
mem_wdata  output  DATA_WIDTH  memory port write data
mem_we  output  1  write strobe
mem_re  output  1  read strobe
mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ready=1
mem_ready  input  1  memory accepts/completes the current byte this cycle
stall  output  1  hold the PC, IF/ID, ID/EX and EX/MEM registers
rd_top  output  DATA_WIDTH  loaded high byte
rd_bot  output  DATA_WIDTH  loaded low byte
rd_valid  output  1  one-cycle pulse: rd_top/rd_bot are valid

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; mem_addr, mem_wdata, mem_we, mem_re, rd_top, rd_bot and rd_valid all 0.
- States: IDLE, ACC_BOT, ACC_TOP, DONE.
- IDLE:
  - If req_valid, latch req_write, req_wide, req_addr, ex_mem_top and ex_mem_bot.
  - Go to ACC_BOT.
- ACC_BOT:
  - Drive mem_addr = latched addr, plus mem_we = write or mem_re = !write.
  - On a store, mem_wdata = latched bot.
  - Hold all of these stable until mem_ready=1.
  - On mem_ready: for a load, capture mem_rdata into rd_bot. Then go to ACC_TOP if wide, else DONE.
- ACC_TOP:
  - Same as ACC_BOT, with mem_addr = latched addr + 1 (mod 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000) and store data = latched top.
  - On mem_ready: for a load, capture mem_rdata into rd_top. Go to DONE.
- DONE:
  - mem_we=mem_re=0; rd_valid=1 if the access was a load.
  - req_valid is ignored, because it is the stale instruction still in EX/MEM. Go to IDLE.
- stall (combinational) = (IDLE && req_valid) || ACC_BOT || ACC_TOP. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- Narrow load: rd_top is forced to 0.
- Strobes: mem_we and mem_re are never asserted together. Both are low in IDLE and DONE.
- Zero-wait memory (mem_ready held at 1):
  - Wide access: stall is high for 3 cycles; rd_valid rises 3 cycles after acceptance.
  - Narrow access: stall is high for 2 cycles.
- Each wait cycle (mem_ready=0) adds exactly one cycle.
- Reset mid-access: state returns to IDLE and the strobes drop on the next edge. No partial write is retried. rd_valid is not pulsed.
- rd_top/rd_bot hold their values until the next load capture.

Decomposition:
- Shared package mem_stage_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACC_BOT=2'd1, ACC_TOP=2'd2, DONE=2'd3);
  - ADDR_WIDTH/DATA_WIDTH defaults.
- No sub-module. The request latch, FSM and address incrementer sit in one module.

Test Plan:
- Wide store at 0x0100, top=0xAB, bot=0xCD, mem_ready=1 → 0x0100 written 0xCD, then 0x0101 written 0xAB; stall high 3 cycles; rd_valid stays 0.
- Wide load at 0x0200, memory holds 0x34@0x0200 and 0x12@0x0201 → rd_bot=0x34, rd_top=0x12, rd_valid one pulse 3 cycles after acceptance.
- Narrow load at 0x0010 holding 0x7F, with mem_ready low for 2 cycles → mem_addr held at 0x0010 throughout; rd_bot=0x7F, rd_top=0x00; stall high 4 cycles.
- Wide store at 0xFFFF → second byte written at 0x0000.
- reset asserted while in ACC_TOP with mem_ready=0 → next cycle state=IDLE, mem_we=0, stall=req_valid, rd_valid=0.
- req_valid held high through DONE → exactly one access performed; a new request accepted only in the following IDLE cycle.
